// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array stream loader.
package systolic_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } loader_state_t;

  localparam int DEFAULT_N          = 3;
  localparam int DEFAULT_DATA_WIDTH = 16;

  // Width of the flat element index; kept at least one bit for the degenerate 1x1 case.
  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/matrix_serializer.sv
// Result capture buffer and row-major valid/ready/last output stage.
module matrix_serializer
  import systolic_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int IDX_W     = idx_width(N)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 capture,
  input  logic                                 active,
  input  logic [IDX_W-1:0]                     idx,
  input  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]  matrix_c,
  output logic                                 out_valid,
  output logic                                 out_last,
  output logic [DATA_WIDTH-1:0]                out_data
);

  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] c_buf;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_buf <= '0;
    end else if (capture) begin
      c_buf <= matrix_c;
    end
  end

  // out_data is selected from held registers, so it stays put while the sink stalls.
  always_comb begin
    out_data = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (idx == IDX_W'(r * N + c)) begin
          out_data = c_buf[r][c];
        end
      end
    end
  end

  assign out_valid = active;
  assign out_last  = active && (idx == IDX_W'(N * N - 1));

endmodule

// File: rtl/matrix_stream_loader.sv
// Serial A/B loader and C drainer wrapped around a systolic matrix multiplier.
module matrix_stream_loader
  import systolic_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int IDX_W     = idx_width(N)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic                                 start,
  input  logic                                 done,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0]  matrix_a,
  output logic [0:N-1][0:N-1][DATA_WIDTH-1:0]  matrix_b,
  input  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]  matrix_c,
  output logic                                 busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  loader_state_t    state;
  logic [IDX_W-1:0] idx;
  logic             at_last;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD_A;
      idx      <= '0;
      matrix_a <= '0;
      matrix_b <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                if (idx == IDX_W'(r * N + c)) matrix_a[r][c] <= in_data;
              end
            end
            if (at_last) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                if (idx == IDX_W'(r * N + c)) matrix_b[r][c] <= in_data;
              end
            end
            if (at_last) begin
              idx   <= '0;
              state <= START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (done) state <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (at_last) begin
              idx   <= '0;
              state <= LOAD_A;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD_A;
          idx   <= '0;
        end
      endcase
    end
  end

  // Handshake outputs decode from registered state only, never from in_valid/out_ready.
  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign start    = (state == START);
  assign busy     = !((state == LOAD_A) && (idx == '0));

  matrix_serializer #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .capture   ((state == WAIT) && done),
    .active    (state == DRAIN),
    .idx       (idx),
    .matrix_c  (matrix_c),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader with a behavioural array model.
module tb_matrix_stream_loader;
  import systolic_pkg::*;

  localparam int N  = 3;
  localparam int DW = 16;

  typedef logic [0:N-1][0:N-1][DW-1:0] mat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          start;
  logic          done;
  mat_t          matrix_a, matrix_b, matrix_c;
  logic          busy;

  int   checks = 0;
  int   failures = 0;
  int   start_count = 0;
  logic auto_done = 1'b1;
  logic done_force = 1'b0;
  logic done_model = 1'b0;
  int   lat_cnt = 0;

  mat_t mat_a, mat_b10, mat_b2i;
  logic [DW-1:0] c_basic [9] = '{300, 360, 420, 660, 810, 960, 1020, 1260, 1500};
  logic [DW-1:0] c_twice [9] = '{2, 4, 6, 8, 10, 12, 14, 16, 18};

  always #5 clk = ~clk;

  matrix_stream_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .start     (start),
    .done      (done),
    .matrix_a  (matrix_a),
    .matrix_b  (matrix_b),
    .matrix_c  (matrix_c),
    .busy      (busy)
  );

  function automatic mat_t product(input mat_t a, input mat_t b);
    mat_t p;
    logic [DW-1:0] acc;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc + DW'(a[r][k] * b[k][c]);
        p[r][c] = acc;
      end
    end
    return p;
  endfunction

  function automatic logic [DW-1:0] elem(input mat_t m, input int k);
    logic [DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r * N + c == k) v = m[r][c];
    return v;
  endfunction

  // Behavioural array: result tracks its operands, done pulses a few cycles after start.
  always @(posedge clk) begin
    matrix_c   <= product(matrix_a, matrix_b);
    done_model <= 1'b0;
    if (reset) begin
      lat_cnt <= 0;
    end else if (start && auto_done) begin
      lat_cnt <= 3;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) done_model <= 1'b1;
    end
  end
  assign done = done_model | done_force;

  always @(negedge clk) begin
    if (start) start_count <= start_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sends elements first..first+cnt-1 of the 2*N*N stream (A then B); called at a negedge.
  task automatic applyStimulus(input mat_t a, input mat_t b, input int first, input int cnt,
                               input bit gaps);
    int guard;
    for (int k = first; k < first + cnt; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
        end
      end
      in_valid = 1'b1;
      in_data  = (k < N * N) ? elem(a, k) : elem(b, k - N * N);
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) checkOutput("in_ready_timeout", 32'(guard), 0);
      @(negedge clk);
      if (k == 2 * N * N - 1) checkOutput("start_after_last_b", 32'(start), 1);
    end
    in_valid = 1'b0;
  endtask

  // Drains N*N results; holds out_ready low for stall_len cycles when element stall_at is showing.
  task automatic drainAndCheck(input string tag, input logic [DW-1:0] exp [9],
                               input int stall_at, input int stall_len);
    int k = 0;
    int guard = 0;
    int stall_left = stall_len;
    while (k < N * N && guard < 200) begin
      if (k == stall_at && stall_left > 0 && out_valid) begin
        out_ready = 1'b0;
        checkOutput({tag, "_stall_valid"}, 32'(out_valid), 1);
        checkOutput({tag, "_stall_data"}, 32'(out_data), 32'(exp[k]));
        checkOutput({tag, "_stall_last"}, 32'(out_last), 0);
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          checkOutput($sformatf("%s_data%0d", tag, k), 32'(out_data), 32'(exp[k]));
          checkOutput($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == N * N - 1));
          k++;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    checkOutput({tag, "_count"}, 32'(k), 32'(N * N));
  endtask

  initial begin
    int starts_before;
    mat_a = '0; mat_b10 = '0; mat_b2i = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[r][c]   = DW'(r * N + c + 1);
        mat_b10[r][c] = DW'(10 * (r * N + c + 1));
        mat_b2i[r][c] = (r == c) ? DW'(2) : DW'(0);
      end

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_last", 32'(out_last), 0);
    checkOutput("rst_start", 32'(start), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_mat_a", 32'(matrix_a == '0), 1);

    $display("[TB] basic flow");
    starts_before = start_count;
    applyStimulus(mat_a, mat_b10, 0, 2 * N * N, 1'b0);
    checkOutput("basic_busy", 32'(busy), 1);
    checkOutput("basic_mat_a", 32'(matrix_a == mat_a), 1);
    checkOutput("basic_mat_b", 32'(matrix_b == mat_b10), 1);
    drainAndCheck("basic", c_basic, -1, 0);
    checkOutput("basic_starts", 32'(start_count - starts_before), 1);
    checkOutput("basic_idle_busy", 32'(busy), 0);

    $display("[TB] input and output backpressure");
    applyStimulus(mat_a, mat_b10, 0, 2 * N * N, 1'b1);
    checkOutput("bp_mat_a", 32'(matrix_a == mat_a), 1);
    checkOutput("bp_mat_b", 32'(matrix_b == mat_b10), 1);
    drainAndCheck("bp", c_basic, 4, 5);

    $display("[TB] ignored inputs");
    auto_done = 1'b0;
    applyStimulus(mat_a, mat_b10, 0, N * N + 2, 1'b0);
    done_force = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("ign_state_loadb", 32'(dut.state), 32'(LOAD_B));
      checkOutput("ign_no_valid", 32'(out_valid), 0);
    end
    done_force = 1'b0;
    applyStimulus(mat_a, mat_b10, N * N + 2, N * N - 2, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      checkOutput("ign_wait_ready", 32'(in_ready), 0);
      checkOutput("ign_state_wait", 32'(dut.state), 32'(WAIT));
    end
    in_valid = 1'b0;
    checkOutput("ign_mat_b", 32'(matrix_b == mat_b10), 1);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    auto_done  = 1'b1;
    drainAndCheck("ign", c_basic, -1, 0);

    $display("[TB] reset during LOAD_B");
    applyStimulus(mat_a, mat_b10, 0, N * N + 4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_state", 32'(dut.state), 32'(LOAD_A));
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_mat_a", 32'(matrix_a == '0), 1);
    checkOutput("mid_rst_mat_b", 32'(matrix_b == '0), 1);
    applyStimulus(mat_a, mat_b10, 0, 2 * N * N, 1'b0);
    drainAndCheck("after_rst", c_basic, -1, 0);

    $display("[TB] back-to-back jobs");
    starts_before = start_count;
    applyStimulus(mat_a, mat_b10, 0, 2 * N * N, 1'b0);
    drainAndCheck("b2b_job1", c_basic, -1, 0);
    applyStimulus(mat_a, mat_b2i, 0, 2 * N * N, 1'b0);
    checkOutput("b2b_mat_b", 32'(matrix_b == mat_b2i), 1);
    drainAndCheck("b2b_job2", c_twice, -1, 0);
    checkOutput("b2b_starts", 32'(start_count - starts_before), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
